sobel_window: RTL and testbench

SOBEL_WINDOW -- requirements
Module: sobel_window

---
 rtl/sobel_window.sv | 112 +++++++++++
 tb/tb_sobel_window.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window.sv
// 3x3 sliding-window generator for raster-order video: two synchronous-read
// line buffers feed a 3x3 register window, one clock from pixel in to window out.
module sobel_window #(
    parameter int DW    = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_sof,
    input  logic [DW-1:0] in_pix,
    output logic          out_valid,
    output logic          out_sof,
    output logic [DW-1:0] pix_0,
    output logic [DW-1:0] pix_1,
    output logic [DW-1:0] pix_2,
    output logic [DW-1:0] pix_3,
    output logic [DW-1:0] pix_4,
    output logic [DW-1:0] pix_5,
    output logic [DW-1:0] pix_6,
    output logic [DW-1:0] pix_7,
    output logic [DW-1:0] pix_8
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col_q, col_d, col_eff;
    logic [RW-1:0] row_q, row_d, row_eff;
    logic          out_valid_q, out_valid_d;
    logic          out_sof_q, out_sof_d;
    logic [DW-1:0] win_q [9];
    logic [DW-1:0] win_d [9];

    logic [DW-1:0] linebuf1 [IMG_W];
    logic [DW-1:0] linebuf2 [IMG_W];
    logic [DW-1:0] lb1_rd_q, lb2_rd_q;

    always_comb begin
        col_eff     = in_sof ? '0 : col_q;
        row_eff     = in_sof ? '0 : row_q;
        col_d       = col_q;
        row_d       = row_q;
        out_valid_d = 1'b0;
        out_sof_d   = 1'b0;
        win_d       = win_q;
        if (in_valid) begin
            if (col_eff == COL_LAST) begin
                col_d = '0;
                row_d = (row_eff == ROW_LAST) ? '0 : row_eff + RW'(1);
            end else begin
                col_d = col_eff + CW'(1);
                row_d = row_eff;
            end
            out_valid_d = (row_eff >= RW'(2)) && (col_eff >= CW'(2));
            out_sof_d   = out_valid_d && (row_eff == RW'(2)) && (col_eff == CW'(2));
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = lb2_rd_q;
            win_d[3] = win_q[4];
            win_d[4] = win_q[5];
            win_d[5] = lb1_rd_q;
            win_d[6] = win_q[7];
            win_d[7] = win_q[8];
            win_d[8] = in_pix;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            for (int i = 0; i < 9; i++) win_q[i] <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            win_q       <= win_d;
        end
    end

    // Read data is fetched one pixel ahead (address col_d) so it is already
    // registered when that column's pixel arrives; the write address is never
    // the read address since IMG_W >= 3.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            linebuf1[col_eff] <= in_pix;
            linebuf2[col_eff] <= lb1_rd_q;
            lb1_rd_q          <= linebuf1[col_d];
            lb2_rd_q          <= linebuf2[col_d];
        end
    end

    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign pix_0     = win_q[0];
    assign pix_1     = win_q[1];
    assign pix_2     = win_q[2];
    assign pix_3     = win_q[3];
    assign pix_4     = win_q[4];
    assign pix_5     = win_q[5];
    assign pix_6     = win_q[6];
    assign pix_7     = win_q[7];
    assign pix_8     = win_q[8];

endmodule

// File: tb/tb_sobel_window.sv
// Bench for sobel_window on a 4x4 image: an image-array reference model pushes
// expected windows to a scoreboard that is popped whenever out_valid is seen.
module tb_sobel_window;
    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sof   = 1'b0;
    logic [DW-1:0] in_pix   = '0;
    logic          out_valid, out_sof;
    logic [DW-1:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
    logic [DW-1:0] pix_a [9];

    assign pix_a[0] = p0; assign pix_a[1] = p1; assign pix_a[2] = p2;
    assign pix_a[3] = p3; assign pix_a[4] = p4; assign pix_a[5] = p5;
    assign pix_a[6] = p6; assign pix_a[7] = p7; assign pix_a[8] = p8;

    sobel_window #(.DW(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pix(in_pix),
        .out_valid(out_valid), .out_sof(out_sof),
        .pix_0(p0), .pix_1(p1), .pix_2(p2), .pix_3(p3), .pix_4(p4),
        .pix_5(p5), .pix_6(p6), .pix_7(p7), .pix_8(p8)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          sof;
        logic [DW-1:0] px [9];
    } win_t;

    typedef struct {
        string         name;
        int            idle_pct;
        logic [DW-1:0] offset;
        bit            use_sof;
        bit            rnd;
        int            exp_win;
        int            exp_sof;
    } vec_t;

    win_t          sb [$];
    logic [DW-1:0] img [H][W];
    logic [DW-1:0] first_win [9];
    logic [DW-1:0] last_win [9];
    bit            got_first;
    int            mr, mc;
    int            checks, failures, win_cnt, sof_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_accept(input logic s, input logic [DW-1:0] p);
        if (s) begin
            mr = 0;
            mc = 0;
        end
        img[mr][mc] = p;
        if (mr >= 2 && mc >= 2) begin
            win_t w;
            w.sof = (mr == 2 && mc == 2);
            for (int k = 0; k < 9; k++) w.px[k] = img[mr-2+k/3][mc-2+k%3];
            sb.push_back(w);
        end
        if (mc == W-1) begin
            mc = 0;
            mr = (mr == H-1) ? 0 : mr + 1;
        end else begin
            mc++;
        end
    endtask

    task automatic monitor(input logic acc);
        if (out_valid) begin
            check("ov_after_accept", 32'(acc), 32'd1);
            win_cnt++;
            if (out_sof) sof_cnt++;
            for (int k = 0; k < 9; k++) begin
                if (!got_first) first_win[k] = pix_a[k];
                last_win[k] = pix_a[k];
            end
            got_first = 1'b1;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_window: got pix_8=%0h expected no window", pix_a[8]);
            end else begin
                win_t w;
                w = sb.pop_front();
                check("win_sof", 32'(out_sof), 32'(w.sof));
                for (int k = 0; k < 9; k++)
                    check($sformatf("win_pix_%0d", k), 32'(pix_a[k]), 32'(w.px[k]));
            end
        end else begin
            check("sof_without_valid", 32'(out_sof), 32'd0);
        end
    endtask

    task automatic cycle(input logic v, input logic s, input logic [DW-1:0] p);
        @(negedge clk);
        in_valid = v;
        in_sof   = s;
        in_pix   = p;
        if (v && rst) model_accept(s, p);
        @(posedge clk);
        #1;
        monitor(v && rst);
    endtask

    task automatic run_frame(input logic [DW-1:0] offset, input bit use_sof,
                             input int idle_pct, input bit rnd);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                logic [DW-1:0] p;
                while (int'($urandom_range(0, 99)) < idle_pct) cycle(1'b0, 1'b0, DW'($urandom));
                p = rnd ? DW'($urandom) : DW'(16*r + c) + offset;
                cycle(1'b1, use_sof && r == 0 && c == 0, p);
            end
        end
    endtask

    task automatic flush_and_count(input string name, input int exp_win, input int exp_sof);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
        check({name, "_windows"}, 32'(win_cnt), 32'(exp_win));
        check({name, "_sofs"}, 32'(sof_cnt), 32'(exp_sof));
        check({name, "_sb_drained"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic start_count();
        win_cnt   = 0;
        sof_cnt   = 0;
        got_first = 1'b0;
    endtask

    initial begin
        vec_t                vecs [4];
        logic [DW-1:0]       exp_first [9];

        vecs[0] = '{"cont",     0,  8'h00, 1'b1, 1'b0, 4, 1};
        vecs[1] = '{"b2b_nsof", 0,  8'h80, 1'b0, 1'b0, 4, 1};
        vecs[2] = '{"idle",     40, 8'h00, 1'b1, 1'b0, 4, 1};
        vecs[3] = '{"rnd_idle", 35, 8'h00, 1'b1, 1'b1, 4, 1};
        exp_first = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
        checks = 0; failures = 0; mr = 0; mc = 0;
        start_count();

        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sof", 32'(out_sof), 32'd0);
        for (int k = 0; k < 9; k++) check($sformatf("rst_pix_%0d", k), 32'(pix_a[k]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 4; i++) begin
            start_count();
            run_frame(vecs[i].offset, vecs[i].use_sof, vecs[i].idle_pct, vecs[i].rnd);
            flush_and_count(vecs[i].name, vecs[i].exp_win, vecs[i].exp_sof);
            if (i == 0) begin
                for (int k = 0; k < 9; k++)
                    check($sformatf("first_win_pix_%0d", k), 32'(first_win[k]), 32'(exp_first[k]));
                check("last_win_pix_8", 32'(last_win[8]), 32'h33);
                check("last_win_pix_4", 32'(last_win[4]), 32'h22);
            end
            if (i == 1) check("b2b_first_pix_0", 32'(first_win[0]), 32'h80);
        end

        // sof re-asserted at position (2,1) of a partially sent frame
        start_count();
        for (int k = 0; k < 9; k++) cycle(1'b1, k == 0, DW'(16*(k/W) + k%W) + 8'h50);
        run_frame(8'h40, 1'b1, 0, 1'b0);
        flush_and_count("mid_sof", 4, 1);
        check("mid_sof_first_pix_8", 32'(first_win[8]), 32'h62);

        // reset pulse right after the window from pixel (2,2) appears
        start_count();
        for (int k = 0; k < 11; k++) cycle(1'b1, k == 0, DW'(16*(k/W) + k%W) + 8'h20);
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        check("pre_rst_sb_drained", 32'(sb.size()), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        #1;
        check("rst_pulse_out_valid", 32'(out_valid), 32'd0);
        check("rst_pulse_out_sof", 32'(out_sof), 32'd0);
        for (int k = 0; k < 9; k++) check($sformatf("rst_pulse_pix_%0d", k), 32'(pix_a[k]), 32'd0);
        mr = 0;
        mc = 0;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        start_count();
        run_frame(8'h10, 1'b0, 0, 1'b0);
        flush_and_count("post_rst", 4, 1);
        check("post_rst_first_pix_0", 32'(first_win[0]), 32'h10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
